// File: rtl/gsim_update.sv
// Gauss-Seidel update stage for the GSIM solver: three-stage pipeline computing
// x_i' = (b + 13*s1 - 6*s2 + s3) / 20 via reciprocal multiply, saturated to BIT_WIDTH.
module gsim_update #(
    parameter int BIT_WIDTH = 32,
    parameter int RECIP     = 52429,
    parameter int RSHIFT    = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BIT_WIDTH-1:0] b_in,
    input  logic signed [BIT_WIDTH-1:0] n1a,
    input  logic signed [BIT_WIDTH-1:0] n1b,
    input  logic signed [BIT_WIDTH-1:0] n2a,
    input  logic signed [BIT_WIDTH-1:0] n2b,
    input  logic signed [BIT_WIDTH-1:0] n3a,
    input  logic signed [BIT_WIDTH-1:0] n3b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BIT_WIDTH-1:0] x_out
);
    localparam int SW = BIT_WIDTH + 1;
    localparam int WW = BIT_WIDTH + 6;
    localparam int RW = 33;
    localparam int PW = WW + RW;

    localparam logic signed [RW-1:0] RECIP_S = {1'b0, 32'(RECIP)};
    localparam logic signed [WW-1:0] K13     = WW'(13);
    localparam logic signed [WW-1:0] K6      = WW'(6);

    function automatic logic signed [BIT_WIDTH-1:0] sat(input logic signed [PW-1:0] q);
        logic signed [PW-1:0] hi;
        logic signed [PW-1:0] lo;
        hi = PW'({1'b0, {(BIT_WIDTH-1){1'b1}}});
        lo = -hi - PW'(1);
        if (q > hi)
            sat = hi[BIT_WIDTH-1:0];
        else if (q < lo)
            sat = lo[BIT_WIDTH-1:0];
        else
            sat = q[BIT_WIDTH-1:0];
    endfunction

    logic                        vld_p0, vld_p1, vld_p2;
    logic signed [BIT_WIDTH-1:0] b_p0;
    logic signed [SW-1:0]        s1_p0, s2_p0, s3_p0;
    logic signed [WW-1:0]        w_p1;

    logic                        en;
    logic signed [SW-1:0]        s1_c, s2_c, s3_c;
    logic signed [WW-1:0]        w_c;
    logic signed [PW-1:0]        p_c, q_c;
    logic signed [BIT_WIDTH-1:0] x_c;

    // The whole pipe advances or freezes together; bubbles keep their slot.
    assign en        = !vld_p2 || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p2;

    // stage 1: pairwise neighbour sums
    assign s1_c = SW'(n1a) + SW'(n1b);
    assign s2_c = SW'(n2a) + SW'(n2b);
    assign s3_c = SW'(n3a) + SW'(n3b);

    // stage 2: weighted combination, exact in WW bits
    assign w_c = WW'(b_p0) + K13 * WW'(s1_p0) - K6 * WW'(s2_p0) + WW'(s3_p0);

    // stage 3: divide by 20 as multiply + arithmetic shift (floor), then saturate
    assign p_c = PW'(w_p1) * PW'(RECIP_S);
    assign q_c = p_c >>> RSHIFT;
    assign x_c = sat(q_c);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            b_p0   <= '0;
            s1_p0  <= '0;
            s2_p0  <= '0;
            s3_p0  <= '0;
            w_p1   <= '0;
            x_out  <= '0;
        end else if (en) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            b_p0   <= b_in;
            s1_p0  <= s1_c;
            s2_p0  <= s2_c;
            s3_p0  <= s3_c;
            w_p1   <= w_c;
            x_out  <= x_c;
        end
    end

endmodule

// File: tb/tb_gsim_update.sv
// Directed self-checking bench for gsim_update (BIT_WIDTH=32).
module tb_gsim_update;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] b_in, n1a, n1b, n2a, n2b, n3a, n3b;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] x_out;

    int total = 0;
    int pass  = 0;

    gsim_update #(.BIT_WIDTH(32), .RECIP(52429), .RSHIFT(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .b_in(b_in), .n1a(n1a), .n1b(n1b), .n2a(n2a), .n2b(n2b), .n3a(n3a), .n3b(n3b),
        .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        b_in = '0; n1a = '0; n1b = '0; n2a = '0; n2b = '0; n3a = '0; n3b = '0;
    endtask

    // Drives one operand set for a single cycle and waits (bounded) for its result.
    task automatic send_one(input logic signed [31:0] b, input logic signed [31:0] a1,
                            input logic signed [31:0] c1, input logic signed [31:0] a2,
                            input logic signed [31:0] c2, input logic signed [31:0] a3,
                            input logic signed [31:0] c3,
                            output logic signed [31:0] res, output int lat);
        b_in = b; n1a = a1; n1b = c1; n2a = a2; n2b = c2; n3a = a3; n3b = c3;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        clear_ops();
        lat = -1;
        res = '0;
        for (int i = 1; i <= 10; i++) begin
            if (out_valid) begin
                lat = i;
                res = x_out;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        clear_ops();
        tick(); tick();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass++;
        total++; if (x_out !== 32'sd0) $display("FAIL reset_x_out got=%0d exp=0", x_out); else pass++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic signed [31:0] r;
        int lat;
        send_one(32'sd100, 0, 0, 0, 0, 0, 0, r, lat);
        total++; if (lat !== 3) $display("FAIL basic_latency got=%0d exp=3", lat); else pass++;
        total++; if (r !== 32'sd5) $display("FAIL basic_value got=%0d exp=5", r); else pass++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL basic_single_pulse got=%b exp=0", out_valid); else pass++;
    endtask

    task automatic test_floor();
        logic signed [31:0] r;
        int lat;
        send_one(-32'sd100, 0, 0, 0, 0, 0, 0, r, lat);
        total++; if (lat !== 3) $display("FAIL floor_latency got=%0d exp=3", lat); else pass++;
        total++; if (r !== -32'sd6) $display("FAIL floor_value got=%0d exp=-6", r); else pass++;
        tick();
    endtask

    task automatic test_weighted();
        logic signed [31:0] r;
        int lat;
        send_one(32'sd0, 32'sd10, 32'sd10, 32'sd5, 32'sd5, 32'sd2, 32'sd2, r, lat);
        total++; if (r !== 32'sd10) $display("FAIL weighted_value got=%0d exp=10", r); else pass++;
        tick();
        // 13*(7+(-3)) - 6*(4+4) + (-1+1) + 1000 = 1004 -> 1004*52429>>20 = 50
        send_one(32'sd1000, 32'sd7, -32'sd3, 32'sd4, 32'sd4, -32'sd1, 32'sd1, r, lat);
        total++; if (r !== 32'sd50) $display("FAIL weighted_mixed got=%0d exp=50", r); else pass++;
        tick();
    endtask

    task automatic test_saturation();
        logic signed [31:0] r;
        int lat;
        send_one(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 0, 0, r, lat);
        total++; if (r !== 32'h7FFFFFFF) $display("FAIL sat_pos got=%h exp=7fffffff", r); else pass++;
        tick();
        send_one(32'h80000000, 32'h80000000, 32'h80000000, 0, 0, 0, 0, r, lat);
        total++; if (r !== 32'h80000000) $display("FAIL sat_neg got=%h exp=80000000", r); else pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int stall = 0;
        bit seen = 1'b0;
        bit acc, drn;
        logic signed [31:0] xv;
        clear_ops();
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            out_ready = (stall > 0) ? 1'b0 : 1'b1;
            in_valid  = (sent < 6);
            b_in      = 32'(20 * (sent + 1));
            #1;
            if (out_valid && !out_ready) begin
                total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else pass++;
                total++; if (x_out !== 32'(got + 1)) $display("FAIL bp_frozen got=%0d exp=%0d", x_out, got + 1); else pass++;
            end
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            xv  = x_out;
            tick();
            if (acc) sent++;
            if (drn) begin
                total++; if (xv !== 32'(got + 1)) $display("FAIL bp_order got=%0d exp=%0d", xv, got + 1); else pass++;
                got++;
                if (!seen) begin
                    seen  = 1'b1;
                    stall = 5;
                end
            end
            if (stall > 0) stall--;
        end
        total++; if (got !== 6) $display("FAIL bp_count got=%0d exp=6", got); else pass++;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup got=%b exp=0", out_valid); else pass++;
    endtask

    task automatic test_reset_midflight();
        logic signed [31:0] r;
        int lat;
        bit stale = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            b_in = 32'(20 * k); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0; rst_n = 1'b0;
        clear_ops();
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); else pass++;
        total++; if (x_out !== 32'sd0) $display("FAIL rst_mid_x_out got=%0d exp=0", x_out); else pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) stale = 1'b1;
        end
        total++; if (stale !== 1'b0) $display("FAIL rst_mid_stale got=%b exp=0", stale); else pass++;
        send_one(32'sd60, 0, 0, 0, 0, 0, 0, r, lat);
        total++; if (lat !== 3) $display("FAIL rst_mid_latency got=%0d exp=3", lat); else pass++;
        total++; if (r !== 32'sd3) $display("FAIL rst_mid_value got=%0d exp=3", r); else pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_floor();
        test_weighted();
        test_saturation();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/gsim_update.md
Name: gsim_update

Overview:
- Arithmetic stage directly downstream of the 16-entry rotating unknown register in the GSIM solver.
- Consumes the current constant b_i and the three symmetric neighbour pairs tapped from that register: (x[i-1], x[i+1]), (x[i-2], x[i+2]) and (x[i-3], x[i+3]).
- Computes the Gauss-Seidel update x_i' = (b_i + 13*(x[i-1]+x[i+1]) - 6*(x[i-2]+x[i+2]) + (x[i-3]+x[i+3])) / 20.
- Three-stage pipeline with a valid/ready handshake on both sides. x_out feeds back to the register's IN port.

Parameters:
- BIT_WIDTH, 32: width of signed two's-complement operands and result.
- RECIP, 52429: unsigned reciprocal constant approximating 2^RSHIFT / 20.
- RSHIFT, 20: right-shift applied after the reciprocal multiply.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  operand set on b_in and n*_* is valid.
- in_ready  out  1  stage accepts an operand set this cycle.
- b_in  in  BIT_WIDTH  signed constant b_i.
- n1a, n1b  in  BIT_WIDTH each  signed distance-1 neighbours.
- n2a, n2b  in  BIT_WIDTH each  signed distance-2 neighbours.
- n3a, n3b  in  BIT_WIDTH each  signed distance-3 neighbours.
- out_valid  out  1  x_out holds a result.
- out_ready  in  1  consumer takes x_out this cycle.
- x_out  out  BIT_WIDTH  signed updated unknown, saturated.

Behaviour:
- Reset (rst_n low at a clock edge): v1, v2, v3 and out_valid become 0, and x_out and all pipeline data registers become 0. Takes effect at that edge and discards any in-flight data.
- Global advance enable: en = !v3 || out_ready. The output is combinational, in_ready = en.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- When en = 1, every stage moves one step: v1 <= in_valid, v2 <= v1, v3 <= v2, and the data moves with it.
- When en = 0, all stage registers hold.
- Bubbles are not collapsed. A stage with v = 0 still occupies its slot.
- Stage 1 forms pairwise sums in BIT_WIDTH+1 signed: s1 = n1a+n1b, s2 = n2a+n2b, s3 = n3a+n3b. b_in is registered alongside.
- Stage 2 forms w = b + 13*s1 - 6*s2 + s3 in BIT_WIDTH+6 signed. This width is exact and cannot overflow; worst case |w| < 41*2^(BIT_WIDTH-1).
- Stage 3:
  - p = w * RECIP, signed by unsigned, computed in full width.
  - q = p >>> RSHIFT (arithmetic shift, so rounding is toward negative infinity).
  - Saturate q to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
  - Register the result as x_out.
- out_valid = v3.
- Latency is 3 cycles from input transfer to out_valid with no stall, and throughput is 1 result per cycle.
- While out_valid=1 && out_ready=0:
  - x_out and out_valid hold stable.
  - in_ready=0; upstream must hold its operands and in_valid.
- If out_ready=1 and in_valid=1 in the same cycle, the result drains and a new operand set enters on the same edge.
- in_valid=0 while en=1 inserts a bubble, and out_valid=0 appears 3 cycles later.
- x_out holds its last value when out_valid=0. Consumers must ignore x_out in that case.
- Reset asserted while out_valid=1 and out_ready=0 drops out_valid at that edge; the held result is lost by design.

Test Plan:
- Basic: b=100, all neighbours 0, in_valid pulse, out_ready=1 -> out_valid high exactly 3 cycles later, x_out=5.
- Floor rounding: b=-100, neighbours 0 -> x_out=-6, since 5242900/2^20 = 5.00002 and the arithmetic shift rounds toward negative infinity.
- Weighted: b=0, n1a=n1b=10, n2a=n2b=5, n3a=n3b=2 -> w=204, x_out=10.
- Saturation (BIT_WIDTH=32):
  - b=n1a=n1b=0x7FFFFFFF, others 0 -> x_out=0x7FFFFFFF.
  - b=n1a=n1b=0x80000000, others 0 -> x_out=0x80000000.
- Back-pressure: stream 6 operand sets with b=20k (k=1..6), drop out_ready for 4 cycles after the first result -> in_ready low during the stall, x_out frozen, outputs 1,2,3,4,5,6 in order with no loss or duplication.
- Reset mid-flight: 3 operand sets in the pipe, rst_n low for one edge -> out_valid=0 and x_out=0 after that edge, no stale result emitted afterwards, and a new input yields correct output 3 cycles after acceptance.
